dot_accum: RTL and testbench

Streaming signed multiply-accumulate back end that sits directly downstream of the 32-bit signed multiplier. It takes one signed 32-bit product per accepted handshake and sums LEN consecutive products into a widened, saturating accumulator. It then presents the dot-product result on an output register with a valid/ready handshake. The output register is separate from the accumulator, so accumulation of the next group overlaps with draining the previous result.

---
 rtl/dot_accum.sv | 130 +++++++++++++
 tb/tb_dot_accum.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum.sv
// dot_accum: streaming signed multiply-accumulate back end.
// Sums LEN consecutive signed 32-bit products into a saturating ACC_W-bit
// accumulator and hands each finished dot product to a separate output
// register with a valid/ready handshake, so the next group can accumulate
// while the previous result waits to be drained.
module dot_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] sum,
    output logic             sum_sat,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [15:0]      cnt
);

    localparam logic [15:0]      LAST_CNT = 16'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Saturating add of a sign-extended product; returns {overflow, value}.
    // The sum is formed one bit wider than the accumulator so that
    // overflow is visible as a disagreement between the top two bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [31:0]      p);
        logic [ACC_W:0] wide;
        logic [ACC_W:0] res;
        wide = {a[ACC_W-1], a} + {{(ACC_W+1-32){p[31]}}, p};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            if (wide[ACC_W] == 1'b0) begin
                res = {1'b1, ACC_MAX};
            end else begin
                res = {1'b1, ACC_MIN};
            end
        end else begin
            res = {1'b0, wide[ACC_W-1:0]};
        end
        return res;
    endfunction

    logic [ACC_W-1:0] acc_r;
    logic             sat_acc_r;
    logic [15:0]      cnt_r;
    logic [ACC_W-1:0] sum_r;
    logic             sum_sat_r;
    logic             sum_valid_r;

    logic [ACC_W:0]   add_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             ovf_s;
    logic             last_s;
    logic             ready_s;
    logic             accept_s;
    logic             drain_s;

    // Next accumulator value, handshake qualifiers and back-pressure.
    // Back-pressure only applies when the closing term of a group would
    // overwrite a result that downstream has not yet taken.
    always_comb begin
        add_s      = sat_add(acc_r, prod);
        ovf_s      = add_s[ACC_W];
        acc_next_s = add_s[ACC_W-1:0];
        last_s     = (cnt_r == LAST_CNT);
        ready_s    = !rst && !clear && !(last_s && sum_valid_r && !sum_ready);
        accept_s   = prod_valid && ready_s;
        drain_s    = sum_valid_r && sum_ready;
    end

    // Accumulator, sticky saturation flag and term counter for the open group.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= {ACC_W{1'b0}};
            sat_acc_r <= 1'b0;
            cnt_r     <= 16'd0;
        end else if (clear) begin
            acc_r     <= {ACC_W{1'b0}};
            sat_acc_r <= 1'b0;
            cnt_r     <= 16'd0;
        end else if (accept_s) begin
            if (last_s) begin
                acc_r     <= {ACC_W{1'b0}};
                sat_acc_r <= 1'b0;
                cnt_r     <= 16'd0;
            end else begin
                acc_r     <= acc_next_s;
                sat_acc_r <= sat_acc_r | ovf_s;
                cnt_r     <= cnt_r + 16'd1;
            end
        end else begin
            acc_r     <= acc_r;
            sat_acc_r <= sat_acc_r;
            cnt_r     <= cnt_r;
        end
    end

    // Output register: loads on the closing term, clears valid on a plain drain.
    // A drain coinciding with a closing term simply replaces the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= {ACC_W{1'b0}};
            sum_sat_r   <= 1'b0;
            sum_valid_r <= 1'b0;
        end else if (accept_s && last_s) begin
            sum_r       <= acc_next_s;
            sum_sat_r   <= sat_acc_r | ovf_s;
            sum_valid_r <= 1'b1;
        end else if (drain_s) begin
            sum_r       <= sum_r;
            sum_sat_r   <= sum_sat_r;
            sum_valid_r <= 1'b0;
        end else begin
            sum_r       <= sum_r;
            sum_sat_r   <= sum_sat_r;
            sum_valid_r <= sum_valid_r;
        end
    end

    assign prod_ready = ready_s;
    assign sum        = sum_r;
    assign sum_sat    = sum_sat_r;
    assign sum_valid  = sum_valid_r;
    assign cnt        = cnt_r;

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum. Three instances share one stimulus stream:
// a (LEN=4, ACC_W=40), b (LEN=2, ACC_W=33), c (LEN=4, ACC_W=33).
// Each scenario resets all of them and then checks only the instance it targets.
module tb_dot_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        prod_valid = 1'b0;
    logic        sum_ready = 1'b1;
    logic [31:0] prod = 32'd0;

    logic        prod_ready_a, sum_sat_a, sum_valid_a;
    logic [39:0] sum_a;
    logic [15:0] cnt_a;
    logic        prod_ready_b, sum_sat_b, sum_valid_b;
    logic [32:0] sum_b;
    logic [15:0] cnt_b;
    logic        prod_ready_c, sum_sat_c, sum_valid_c;
    logic [32:0] sum_c;
    logic [15:0] cnt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dot_accum #(.LEN(4), .ACC_W(40)) u_a (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_a), .clear(clear), .sum(sum_a),
        .sum_sat(sum_sat_a), .sum_valid(sum_valid_a), .sum_ready(sum_ready),
        .cnt(cnt_a)
    );

    dot_accum #(.LEN(2), .ACC_W(33)) u_b (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_b), .clear(clear), .sum(sum_b),
        .sum_sat(sum_sat_b), .sum_valid(sum_valid_b), .sum_ready(sum_ready),
        .cnt(cnt_b)
    );

    dot_accum #(.LEN(4), .ACC_W(33)) u_c (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_c), .clear(clear), .sum(sum_c),
        .sum_sat(sum_sat_c), .sum_valid(sum_valid_c), .sum_ready(sum_ready),
        .cnt(cnt_c)
    );

    // One-cycle reset of every instance, leaving inputs idle and sum_ready high.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod = 32'd0; sum_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one product for the next rising edge.
    task automatic push(input logic [31:0] p);
        @(negedge clk);
        prod = p; prod_valid = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (prod_ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b want 0", prod_ready_a); end
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %0b want 0", sum_valid_a); end
        checks++; if (sum_a !== 40'd0) begin errors++; $display("FAIL reset_sum: got %0h want 0", sum_a); end
        checks++; if (sum_sat_a !== 1'b0) begin errors++; $display("FAIL reset_sum_sat: got %0b want 0", sum_sat_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        rst = 1'b0;
        #1;
        checks++; if (prod_ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0b want 1", prod_ready_a); end
    endtask

    task automatic test_basic();
        logic [31:0] v [4];
        v[0] = 32'd3; v[1] = 32'hFFFF_FFFB; v[2] = 32'd7; v[3] = 32'd100000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(v[i]);
            checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_early[%0d]: got %0b want 0", i, sum_valid_a); end
            #1;
            checks++; if (prod_ready_a !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %0b want 1", i, prod_ready_a); end
        end
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", sum_valid_a); end
        checks++; if (sum_a !== 40'd100005) begin errors++; $display("FAIL basic_sum: got %0d want 100005", sum_a); end
        checks++; if (sum_sat_a !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b want 0", sum_sat_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL basic_cnt: got %0d want 0", cnt_a); end
        @(negedge clk);
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %0b want 0", sum_valid_a); end
    endtask

    task automatic test_exact_edges();
        do_reset();
        push(32'h7FFF_FFFF);
        push(32'h7FFF_FFFF);
        push(32'h8000_0000);
        checks++; if (sum_b !== 33'd4294967294) begin errors++; $display("FAIL edge_pos_sum: got %0h want 0fffffffe", sum_b); end
        checks++; if (sum_sat_b !== 1'b0) begin errors++; $display("FAIL edge_pos_sat: got %0b want 0", sum_sat_b); end
        checks++; if (sum_valid_b !== 1'b1) begin errors++; $display("FAIL edge_pos_valid: got %0b want 1", sum_valid_b); end
        push(32'h8000_0000);
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_b !== 33'h1_0000_0000) begin errors++; $display("FAIL edge_neg_sum: got %0h want 100000000", sum_b); end
        checks++; if (sum_sat_b !== 1'b0) begin errors++; $display("FAIL edge_neg_sat: got %0b want 0", sum_sat_b); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push((i < 4) ? 32'h7FFF_FFFF : 32'd1);
            if (i == 4) begin
                checks++; if (sum_c !== 33'h0_FFFF_FFFF) begin errors++; $display("FAIL sat_sum: got %0h want 0ffffffff", sum_c); end
                checks++; if (sum_sat_c !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b want 1", sum_sat_c); end
            end
        end
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_c !== 33'd4) begin errors++; $display("FAIL sat_next_sum: got %0h want 4", sum_c); end
        checks++; if (sum_sat_c !== 1'b0) begin errors++; $display("FAIL sat_next_flag: got %0b want 0", sum_sat_c); end
        checks++; if (sum_valid_c !== 1'b1) begin errors++; $display("FAIL sat_next_valid: got %0b want 1", sum_valid_c); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        sum_ready = 1'b0;
        prod = 32'd1; prod_valid = 1'b1;
        push(32'd2);
        #1;
        checks++; if (prod_ready_b !== 1'b1) begin errors++; $display("FAIL stall_ready_first: got %0b want 1", prod_ready_b); end
        push(32'd3);
        checks++; if (sum_b !== 33'd3 || sum_valid_b !== 1'b1) begin errors++; $display("FAIL stall_first_result: got %0d/%0b want 3/1", sum_b, sum_valid_b); end
        push(32'd4);
        #1;
        checks++; if (prod_ready_b !== 1'b0) begin errors++; $display("FAIL stall_ready_drop: got %0b want 0", prod_ready_b); end
        checks++; if (cnt_b !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", cnt_b); end
        @(negedge clk);
        checks++; if (sum_b !== 33'd3 || sum_valid_b !== 1'b1) begin errors++; $display("FAIL stall_hold: got %0d/%0b want 3/1", sum_b, sum_valid_b); end
        #1;
        checks++; if (prod_ready_b !== 1'b0) begin errors++; $display("FAIL stall_ready_held: got %0b want 0", prod_ready_b); end
        sum_ready = 1'b1;
        #1;
        checks++; if (prod_ready_b !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b want 1", prod_ready_b); end
        push(32'd5);
        checks++; if (sum_b !== 33'd7 || sum_valid_b !== 1'b1) begin errors++; $display("FAIL stall_second_result: got %0d/%0b want 7/1", sum_b, sum_valid_b); end
        checks++; if (cnt_b !== 16'd0) begin errors++; $display("FAIL stall_cnt_wrap: got %0d want 0", cnt_b); end
        push(32'd6);
        checks++; if (sum_valid_b !== 1'b0) begin errors++; $display("FAIL stall_drained: got %0b want 0", sum_valid_b); end
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_b !== 33'd11 || sum_valid_b !== 1'b1) begin errors++; $display("FAIL stall_third_result: got %0d/%0b want 11/1", sum_b, sum_valid_b); end
    endtask

    task automatic test_clear();
        do_reset();
        push(32'd10);
        push(32'd20);
        @(negedge clk);
        clear = 1'b1; prod = 32'd99; prod_valid = 1'b1;
        #1;
        checks++; if (prod_ready_a !== 1'b0) begin errors++; $display("FAIL clear_ready: got %0b want 0", prod_ready_a); end
        @(negedge clk);
        clear = 1'b0;
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", cnt_a); end
        prod = 32'd1;
        push(32'd2);
        push(32'd3);
        push(32'd4);
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL clear_valid_early: got %0b want 0", sum_valid_a); end
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_a !== 40'd10 || sum_valid_a !== 1'b1) begin errors++; $display("FAIL clear_sum: got %0d/%0b want 10/1", sum_a, sum_valid_a); end
    endtask

    task automatic test_reset_mid_group();
        do_reset();
        @(negedge clk);
        sum_ready = 1'b0;
        prod = 32'd1; prod_valid = 1'b1;
        push(32'd2);
        push(32'd3);
        push(32'd4);
        push(32'd5);
        push(32'd6);
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (cnt_a !== 16'd2 || sum_valid_a !== 1'b1 || sum_a !== 40'd10) begin errors++; $display("FAIL midrst_pre: got cnt=%0d valid=%0b sum=%0d want 2/1/10", cnt_a, sum_valid_a, sum_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", sum_valid_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", cnt_a); end
        checks++; if (sum_a !== 40'd0) begin errors++; $display("FAIL midrst_sum: got %0d want 0", sum_a); end
        #1;
        checks++; if (prod_ready_a !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", prod_ready_a); end
        sum_ready = 1'b1;
        push(32'd1);
        push(32'd1);
        push(32'd1);
        push(32'd2);
        @(negedge clk);
        prod_valid = 1'b0;
        checks++; if (sum_a !== 40'd5 || sum_valid_a !== 1'b1) begin errors++; $display("FAIL midrst_next_sum: got %0d/%0b want 5/1", sum_a, sum_valid_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exact_edges();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
